// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NM masters share one slave port. The bus is
// granted for a whole cycle (cyc-to-cyc). Only the owner sees ack/err/data.
// A per-transfer watchdog turns a stalled access into an error so that a
// silent slave cannot hang the owning master.
module wb_rr_arbiter #(
  parameter int NM      = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NM-1:0]    i_mcyc,
  input  logic [NM-1:0]    i_mstb,
  input  logic [NM-1:0]    i_mwe,
  input  logic [NM*AW-1:0] i_maddr,
  input  logic [NM*DW-1:0] i_mdata,
  input  logic [NM*SW-1:0] i_msel,
  output logic [NM-1:0]    o_mack,
  output logic [NM*DW-1:0] o_mdata,
  output logic [NM-1:0]    o_merr,
  output logic             o_scyc,
  output logic             o_sstb,
  output logic             o_swe,
  output logic [AW-1:0]    o_saddr,
  output logic [DW-1:0]    o_sdata,
  output logic [SW-1:0]    o_ssel,
  input  logic             i_sack,
  input  logic [DW-1:0]    i_sdata,
  input  logic             i_serr,
  output logic [NM-1:0]    o_grant,
  output logic             o_busy
);

  localparam int IW      = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW_RAW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int CW      = (CW_RAW > 0) ? CW_RAW : 1;
  localparam int TO_LIM  = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;
  localparam bit WDOG_EN = (TIMEOUT > 0);

  localparam logic [CW-1:0] WDOG_LAST = CW'(TO_LIM);
  localparam logic [IW-1:0] LAST_RST  = IW'(NM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OWN   = 2'd1,
    S_ABORT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] wdog_q, wdog_d;
  logic          abort_first_q, abort_first_d;

  logic [AW-1:0] maddr_a [NM];
  logic [DW-1:0] mdata_a [NM];
  logic [SW-1:0] msel_a  [NM];

  logic [IW-1:0] pick_s;
  logic          pick_vld_s;
  logic [IW:0]   cand_sum_s;
  logic [IW-1:0] cand_s;
  logic          own_cyc_s;
  logic          own_stb_s;
  logic          stall_s;

  // Split the flat per-master buses into arrays indexed by master number.
  always_comb begin
    for (int k = 0; k < NM; k++) begin
      maddr_a[k] = i_maddr[k*AW +: AW];
      mdata_a[k] = i_mdata[k*DW +: DW];
      msel_a[k]  = i_msel[k*SW +: SW];
    end
  end

  // Round-robin pick: first requester after the last owner, with wrap.
  always_comb begin
    pick_s     = {IW{1'b0}};
    pick_vld_s = 1'b0;
    cand_sum_s = {(IW+1){1'b0}};
    cand_s     = {IW{1'b0}};
    for (int i = 1; i <= NM; i++) begin
      cand_sum_s = {1'b0, last_q} + (IW+1)'(i);
      if (cand_sum_s >= (IW+1)'(NM)) begin
        cand_sum_s = cand_sum_s - (IW+1)'(NM);
      end else begin
        cand_sum_s = cand_sum_s;
      end
      cand_s = cand_sum_s[IW-1:0];
      if (!pick_vld_s && i_mcyc[cand_s]) begin
        pick_vld_s = 1'b1;
        pick_s     = cand_s;
      end else begin
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Owner's request lines and the "stalled transfer" condition.
  always_comb begin
    own_cyc_s = i_mcyc[owner_q];
    own_stb_s = i_mstb[owner_q];
    stall_s   = (state_q == S_OWN) && own_stb_s && !i_sack && !i_serr;
  end

  // Next-state logic, release bookkeeping and watchdog counter.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    wdog_d        = {CW{1'b0}};
    abort_first_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld_s) begin
          state_d = S_OWN;
          owner_d = pick_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OWN: begin
        if (!own_cyc_s) begin
          // Release (or abandoned transfer): released owner goes last.
          state_d = S_IDLE;
          last_d  = owner_q;
        end else if (WDOG_EN && stall_s && (wdog_q == WDOG_LAST)) begin
          state_d       = S_ABORT;
          abort_first_d = 1'b1;
        end else if (WDOG_EN && stall_s) begin
          wdog_d = wdog_q + CW'(1);
        end else begin
          wdog_d = {CW{1'b0}};
        end
      end
      S_ABORT: begin
        if (!own_cyc_s) begin
          state_d = S_IDLE;
          last_d  = owner_q;
        end else begin
          state_d = S_ABORT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output routing: owner's request to the slave, slave response to the owner.
  always_comb begin
    o_scyc  = 1'b0;
    o_sstb  = 1'b0;
    o_swe   = 1'b0;
    o_saddr = {AW{1'b0}};
    o_sdata = {DW{1'b0}};
    o_ssel  = {SW{1'b0}};
    o_mack  = {NM{1'b0}};
    o_merr  = {NM{1'b0}};
    o_mdata = {(NM*DW){1'b0}};
    o_grant = {NM{1'b0}};
    o_busy  = 1'b0;
    case (state_q)
      S_OWN: begin
        o_scyc           = own_cyc_s;
        o_sstb           = own_stb_s;
        o_swe            = i_mwe[owner_q];
        o_saddr          = maddr_a[owner_q];
        o_sdata          = mdata_a[owner_q];
        o_ssel           = msel_a[owner_q];
        o_mack[owner_q]  = i_sack;
        o_merr[owner_q]  = i_serr;
        o_grant[owner_q] = 1'b1;
        o_busy           = 1'b1;
        for (int k = 0; k < NM; k++) begin
          if (owner_q == IW'(k)) begin
            o_mdata[k*DW +: DW] = i_sdata;
          end else begin
            o_mdata[k*DW +: DW] = {DW{1'b0}};
          end
        end
      end
      S_ABORT: begin
        // Slave sees the cycle dropped; owner gets a one-cycle error.
        o_merr[owner_q]  = abort_first_q;
        o_grant[owner_q] = 1'b1;
        o_busy           = 1'b1;
      end
      default: begin
        o_busy = 1'b0;
      end
    endcase
  end

  // State registers; reset makes master 0 win the first arbitration.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= S_IDLE;
      owner_q       <= {IW{1'b0}};
      last_q        <= LAST_RST;
      wdog_q        <= {CW{1'b0}};
      abort_first_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      wdog_q        <= wdog_d;
      abort_first_q <= abort_first_d;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter (NM=4, TIMEOUT=4). A behavioural
// model tracks owner / last owner / stalled-cycle count and predicts every
// output each cycle; directed scenarios add explicit expected sequences.
module tb_wb_rr_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    mcyc, mstb, mwe;
  logic [NM*AW-1:0] maddr;
  logic [NM*DW-1:0] mdata;
  logic [NM*SW-1:0] msel;
  logic [NM-1:0]    o_mack, o_merr, o_grant;
  logic [NM*DW-1:0] o_mdata;
  logic             o_scyc, o_sstb, o_swe, o_busy;
  logic [AW-1:0]    o_saddr;
  logic [DW-1:0]    o_sdata;
  logic [SW-1:0]    o_ssel;
  logic             sack, serr;
  logic [DW-1:0]    sdata;

  wb_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_mcyc(mcyc), .i_mstb(mstb), .i_mwe(mwe),
    .i_maddr(maddr), .i_mdata(mdata), .i_msel(msel),
    .o_mack(o_mack), .o_mdata(o_mdata), .o_merr(o_merr),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
    .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
    .i_sack(sack), .i_sdata(sdata), .i_serr(serr),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owner (-1 = bus free), last owner, stalled cycles so far
  int m_owner, m_last, m_stall, m_ab_n;
  bit m_abort, m_done;

  // Stimulus knobs
  logic [NM-1:0] k_req;
  int  k_lat;     // stalled cycles before the slave answers, -1 = never
  bit  k_err, k_rand, k_fix3;
  int  k_hold;    // cycles the owner keeps cyc up in ABORT

  // Observation records
  logic [NM-1:0] g_seen[$];
  logic [NM-1:0] g_prev;
  int n_merr, n_mack, n_stb, n_nocyc, n_direct, n_hit;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_last = NM - 1; m_stall = 0; m_ab_n = 0;
    m_abort = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else if (m_owner < 0) begin
      for (int i = 1; i <= NM; i++) begin
        int c;
        c = (m_last + i) % NM;
        if (m_owner < 0 && mcyc[c]) m_owner = c;
      end
      m_stall = 0; m_abort = 1'b0; m_done = 1'b0; m_ab_n = 0;
      if (m_owner >= 0 && k_rand) begin
        k_lat  = $urandom_range(0, 5);
        k_hold = $urandom_range(0, 2);
      end
    end else if (m_abort) begin
      if (!mcyc[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_abort = 1'b0;
      end else begin
        m_ab_n++;
      end
    end else if (!mcyc[m_owner]) begin
      m_last = m_owner; m_owner = -1; m_stall = 0;
    end else if (mstb[m_owner] && (sack || serr)) begin
      m_done = 1'b1; m_stall = 0;
    end else if (mstb[m_owner]) begin
      m_stall++;
      if (m_stall == TO) begin
        m_abort = 1'b1; m_ab_n = 0; m_stall = 0;
      end
    end else begin
      m_stall = 0;
    end
  endtask

  task automatic drive();
    for (int k = 0; k < NM; k++) begin
      maddr[k*AW +: AW] = $urandom;
      mdata[k*DW +: DW] = $urandom;
      msel[k*SW +: SW]  = SW'($urandom);
      mwe[k]            = 1'($urandom);
      if (k == m_owner && !m_abort) begin
        mcyc[k] = !m_done;
        mstb[k] = !m_done && (!k_rand || ($urandom % 4 != 0));
        if (k_rand && ($urandom % 24 == 0)) mcyc[k] = 1'b0;
      end else if (k == m_owner) begin
        mcyc[k] = (m_ab_n < k_hold);
        mstb[k] = mcyc[k];
      end else begin
        mcyc[k] = k_rand ? 1'($urandom) : k_req[k];
        mstb[k] = 1'($urandom);
      end
    end
    if (k_fix3) begin
      maddr[3*AW +: AW] = 32'h0000_1234;
      mdata[3*DW +: DW] = 32'hDEAD_BEEF;
      msel[3*SW +: SW]  = 4'hF;
      mwe[3]            = 1'b1;
    end
    if (k_rand) k_err = ($urandom % 6 == 0);
    sdata = $urandom;
    sack  = 1'b0;
    serr  = 1'b0;
    if (m_owner >= 0 && !m_abort && mcyc[m_owner] && mstb[m_owner] &&
        k_lat >= 0 && m_stall >= k_lat) begin
      sack = !k_err;
      serr = k_err;
    end
  endtask

  task automatic check_outputs();
    logic [NM-1:0]    e_grant, e_mack, e_merr;
    logic [NM*DW-1:0] e_mdata;
    logic             e_scyc, e_sstb, e_busy;
    e_grant = '0; e_mack = '0; e_merr = '0; e_mdata = '0;
    e_scyc = 1'b0; e_sstb = 1'b0; e_busy = 1'b0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      e_busy = 1'b1;
      if (!m_abort) begin
        e_scyc = mcyc[m_owner];
        e_sstb = mstb[m_owner];
        e_mack[m_owner] = sack;
        e_merr[m_owner] = serr;
        e_mdata[m_owner*DW +: DW] = sdata;
        chk("swe",   o_swe,   mwe[m_owner]);
        chk("saddr", o_saddr, maddr[m_owner*AW +: AW]);
        chk("sdata", o_sdata, mdata[m_owner*DW +: DW]);
        chk("ssel",  o_ssel,  msel[m_owner*SW +: SW]);
      end else begin
        e_merr[m_owner] = (m_ab_n == 0);
      end
    end else begin
      chk("idle_swe",   o_swe,   1'b0);
      chk("idle_saddr", o_saddr, '0);
      chk("idle_sdata", o_sdata, '0);
      chk("idle_ssel",  o_ssel,  '0);
    end
    chk("grant", o_grant, e_grant);
    chk("busy",  o_busy,  e_busy);
    chk("scyc",  o_scyc,  e_scyc);
    chk("sstb",  o_sstb,  e_sstb);
    chk("mack",  o_mack,  e_mack);
    chk("merr",  o_merr,  e_merr);
    chk("mdata", o_mdata, e_mdata);
  endtask

  task automatic tick_a();
    drive();
    #2;
    check_outputs();
    if (o_grant != '0 && g_prev == '0) g_seen.push_back(o_grant);
    if (o_grant != '0 && g_prev != '0 && o_grant != g_prev) n_direct++;
    g_prev = o_grant;
    if (o_merr != '0) n_merr++;
    if (o_mack != '0) n_mack++;
    if (o_sstb) n_stb++;
    if (o_busy && !o_scyc) n_nocyc++;
  endtask

  task automatic tick_b();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic tick();
    tick_a();
    tick_b();
  endtask

  task automatic clear_obs();
    g_seen.delete();
    n_merr = 0; n_mack = 0; n_stb = 0; n_nocyc = 0; n_direct = 0; n_hit = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_obs();
  endtask

  initial begin
    logic [NM-1:0] exp_seq [5];
    rst = 1'b1; mcyc = '0; mstb = '0; mwe = '0; maddr = '0; mdata = '0; msel = '0;
    sack = 1'b0; serr = 1'b0; sdata = '0; g_prev = '0;
    k_req = '0; k_lat = 1; k_err = 1'b0; k_rand = 1'b0; k_fix3 = 1'b0; k_hold = 1;
    model_reset();
    clear_obs();
    @(posedge clk);
    @(negedge clk);
    tick();
    chk("rst_grant", o_grant, 4'b0000);
    chk("rst_busy",  o_busy,  1'b0);
    chk("rst_scyc",  o_scyc,  1'b0);
    rst = 1'b0;
    clear_obs();

    // Masters 0 and 2 alternate, slave acks after one stalled cycle
    k_req = 4'b0101; k_lat = 1;
    for (int i = 0; i < 30; i++) tick();
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0100; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0100;
    for (int i = 0; i < 4; i++)
      chk("alt_grant", (i < g_seen.size()) ? g_seen[i] : 4'b0000, exp_seq[i]);
    chk("alt_no_idle_gap", n_direct, 0);

    // All four request continuously, single-beat each
    k_req = 4'b1111; k_lat = 0;
    do_reset();
    for (int i = 0; i < 25; i++) tick();
    exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++)
      chk("rr_grant", (i < g_seen.size()) ? g_seen[i] : 4'b0000, exp_seq[i]);
    chk("rr_no_idle_gap", n_direct, 0);

    // Master 1 stalls forever: abort after 4 stalled cycles
    k_req = 4'b0010; k_lat = -1; k_hold = 2;
    do_reset();
    tick(); tick();
    k_req = 4'b0000;
    for (int i = 0; i < 10; i++) tick();
    chk("to_stb_cycles", n_stb, 4);
    chk("to_merr_cycles", n_merr, 1);
    chk("to_abort_cycles", n_nocyc, 3);
    chk("to_mack_cycles", n_mack, 0);
    chk("to_end_grant", o_grant, 4'b0000);

    // Ack on the 4th stalled cycle completes normally
    k_req = 4'b0010; k_lat = 3;
    do_reset();
    tick(); tick();
    k_req = 4'b0000;
    for (int i = 0; i < 10; i++) tick();
    chk("late_ack_mack", n_mack, 1);
    chk("late_ack_merr", n_merr, 0);
    chk("late_ack_stb", n_stb, 4);
    chk("late_ack_nocyc", n_nocyc, 1);

    // Master 3 write routed unchanged; slave error goes to master 3 only
    k_req = 4'b1000; k_lat = 0; k_err = 1'b1; k_fix3 = 1'b1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick_a();
      if (m_owner == 3 && !m_abort && mstb[3]) begin
        n_hit++;
        chk("wr_saddr", o_saddr, 32'h0000_1234);
        chk("wr_sdata", o_sdata, 32'hDEAD_BEEF);
        chk("wr_ssel",  o_ssel,  4'hF);
        chk("wr_swe",   o_swe,   1'b1);
        chk("wr_merr",  o_merr,  4'b1000);
        chk("wr_mack",  o_mack,  4'b0000);
      end
      tick_b();
    end
    chk("wr_seen", n_hit > 0, 1'b1);
    k_err = 1'b0; k_fix3 = 1'b0;

    // Reset while master 2 owns the bus
    k_req = 4'b0100; k_lat = -1; k_hold = 1;
    do_reset();
    tick(); tick(); tick();
    k_req = 4'b0101;
    rst = 1'b1;
    tick_a();
    chk("pre_rst_grant", o_grant, 4'b0100);
    tick_b();
    rst = 1'b0;
    tick_a();
    chk("post_rst_grant", o_grant, 4'b0000);
    chk("post_rst_scyc",  o_scyc,  1'b0);
    chk("post_rst_busy",  o_busy,  1'b0);
    chk("post_rst_merr",  o_merr,  4'b0000);
    tick_b();
    tick_a();
    chk("post_rst_winner", o_grant, 4'b0001);
    tick_b();
    k_req = 4'b0000;
    for (int i = 0; i < 10; i++) tick();

    // Randomised traffic against the model
    k_rand = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
